// File: rtl/ft245_pkg.sv
// Shared constants for the FT245 receive path: pointer sizing, skid depth and idle counter width.
package ft245_pkg;

   localparam int FT245_DEFAULT_DEPTH = 16;
   localparam int FT245_PTR_W         = $clog2(FT245_DEFAULT_DEPTH) + 1;
   // FT245 keeps streaming this many beats after read-enable drops
   localparam int FT245_DEFAULT_SKID  = 3;
   localparam int FT245_IDLE_CNT_W    = 10;

   function automatic int ft245_ptr_width(input int depth_entries);
      return $clog2(depth_entries) + 1;
   endfunction

endpackage

// File: rtl/ft245_fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read (first-word-fall-through).
module ft245_fifo_ram #(
   parameter int width  = 9,
   parameter int addr_w = 4
) (
   input  logic              ft245_dclk,
   input  logic              we_i,
   input  logic [addr_w-1:0] waddr_i,
   input  logic [width-1:0]  wdata_i,
   input  logic [addr_w-1:0] raddr_i,
   output logic [width-1:0]  rdata_o
);

   logic [width-1:0] mem_q [2**addr_w];

   always_ff @(posedge ft245_dclk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ft245_rx_skid_fifo.sv
// FT245 receive skid FIFO: early tready throttle, skid absorption, zero-keep drop, sticky overflow.
// Optional idle-timeout packet framing (tlast) is built when FT245_RX_TLAST_EN is defined.
module ft245_rx_skid_fifo
   import ft245_pkg::*;
#(
   parameter int bus_width    = 1,
   parameter int depth        = FT245_DEFAULT_DEPTH,
   parameter int skid         = FT245_DEFAULT_SKID,
   parameter int idle_timeout = 32
) (
   input  logic                     ft245_dclk,
   input  logic                     rstn,
   input  logic [bus_width*8-1:0]   s_axis_tdata,
   input  logic [bus_width-1:0]     s_axis_tkeep,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   output logic [bus_width*8-1:0]   m_axis_tdata,
   output logic [bus_width-1:0]     m_axis_tkeep,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [$clog2(depth):0]   occupancy,
   output logic                     overflow
);

   localparam int PW = ft245_ptr_width(depth);
   localparam int AW = PW - 1;
   localparam int DW = bus_width * 8;
   localparam logic [PW-1:0] DEPTH_C  = PW'(depth);
   localparam logic [PW-1:0] THRESH_C = PW'(depth - skid);
   localparam logic [PW-1:0] ONE_C    = PW'(1);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] occ, occ_d;
   logic          overflow_q, overflow_d;
   logic          s_tready_q, s_tready_d;
   logic          keep_nz, full, rd_en, wr_en;
   logic [bus_width*9-1:0] ram_wdata, ram_rdata;

   // Natural binary wrap of the extra MSB makes the difference the true fill level
   assign occ     = wr_ptr_q - rd_ptr_q;
   assign keep_nz = |s_axis_tkeep;
   assign full    = (occ == DEPTH_C);
   assign rd_en   = m_axis_tvalid & m_axis_tready;
   // Accepted regardless of s_axis_tready: beats in flight land in the skid slots
   assign wr_en   = s_axis_tvalid & keep_nz & (~full | rd_en);

   always_comb begin
      wr_ptr_d   = wr_ptr_q + {{(PW-1){1'b0}}, wr_en};
      rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, rd_en};
      occ_d      = wr_ptr_d - rd_ptr_d;
      s_tready_d = (occ_d < THRESH_C);
      overflow_d = overflow_q | (s_axis_tvalid & keep_nz & full & ~rd_en);
   end

   always_ff @(posedge ft245_dclk) begin
      if (!rstn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         s_tready_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         s_tready_q <= s_tready_d;
      end
   end

   assign ram_wdata = {s_axis_tkeep, s_axis_tdata};

   ft245_fifo_ram #(
      .width  (bus_width * 9),
      .addr_w (AW)
   ) u_ram (
      .ft245_dclk (ft245_dclk),
      .we_i       (wr_en),
      .waddr_i    (wr_ptr_q[AW-1:0]),
      .wdata_i    (ram_wdata),
      .raddr_i    (rd_ptr_q[AW-1:0]),
      .rdata_o    (ram_rdata)
   );

   assign m_axis_tdata  = ram_rdata[DW-1:0];
   assign m_axis_tkeep  = ram_rdata[bus_width*9-1:DW];
   assign s_axis_tready = s_tready_q;
   assign overflow      = overflow_q;
   assign occupancy     = occ;

`ifdef FT245_RX_TLAST_EN
   localparam logic [FT245_IDLE_CNT_W-1:0] IDLE_LIM = FT245_IDLE_CNT_W'(idle_timeout);

   logic [FT245_IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic                        timed_out, hold;

   assign timed_out = (idle_cnt_q >= IDLE_LIM);

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (wr_en) begin
         idle_cnt_d = '0;
      end else if (!timed_out) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge ft245_dclk) begin
      if (!rstn) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_d_unused_guard: idle_cnt_q <= idle_cnt_d;
      end
   end

   // The last stored beat waits for either more data or the idle timeout
   assign hold          = (occ == ONE_C) & ~timed_out;
   assign m_axis_tvalid = (occ != '0) & ~hold;
   assign m_axis_tlast  = m_axis_tvalid & (((occ == ONE_C) & timed_out) | ~(&m_axis_tkeep));
`else
   assign m_axis_tvalid = (occ != '0);
   assign m_axis_tlast  = 1'b0;
`endif

endmodule

// File: tb/tb_ft245_rx_skid_fifo.sv
// Self-checking bench for ft245_rx_skid_fifo against a queue-based reference model.
module tb_ft245_rx_skid_fifo;

   localparam int DEPTH  = 16;
   localparam int SKID   = 3;
   localparam int IDLE_T = 32;

   logic       ft245_dclk;
   logic       rstn;
   logic [7:0] s_axis_tdata;
   logic [0:0] s_axis_tkeep;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic [0:0] m_axis_tkeep;
   logic       m_axis_tvalid;
   logic       m_axis_tready;
   logic       m_axis_tlast;
   logic [4:0] occupancy;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: stored beats as {keep, data}, plus expected flags
   logic [8:0] exp_q[$];
   logic [7:0] got_q[$];
   logic       m_ovf;
   logic       m_trdy;

   ft245_rx_skid_fifo #(
      .bus_width    (1),
      .depth        (DEPTH),
      .skid         (SKID),
      .idle_timeout (IDLE_T)
   ) dut (
      .ft245_dclk    (ft245_dclk),
      .rstn          (rstn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .occupancy     (occupancy),
      .overflow      (overflow)
   );

   initial ft245_dclk = 1'b0;
   always #5 ft245_dclk = ~ft245_dclk;

   // Drive one cycle starting from a falling edge; returns at the next falling edge.
   task automatic tick(input logic v, input logic [7:0] d, input logic k, input logic mr);
      bit rd, wr, full;
      s_axis_tvalid = v;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      m_axis_tready = mr;
      if (m_axis_tvalid && mr) got_q.push_back(m_axis_tdata);
      @(posedge ft245_dclk);
      if (!rstn) begin
         exp_q.delete();
         m_ovf  = 1'b0;
         m_trdy = 1'b0;
      end else begin
         full = (exp_q.size() == DEPTH);
         rd   = (exp_q.size() != 0) && mr;
         wr   = v && (k != 0) && (!full || rd);
         if (v && (k != 0) && full && !rd) m_ovf = 1'b1;
         if (rd) void'(exp_q.pop_front());
         if (wr) exp_q.push_back({k, d});
         m_trdy = (exp_q.size() < DEPTH - SKID);
      end
      @(negedge ft245_dclk);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      tick(1'b1, 8'h99, 1'b1, 1'b0);
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || occupancy !== 5'd0 || overflow !== 1'b0 ||
          m_axis_tlast !== 1'b0 || s_axis_tready !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_values: tvalid=%b occ=%0d ovf=%b tlast=%b trdy=%b, required 0/0/0/0/0",
                  m_axis_tvalid, occupancy, overflow, m_axis_tlast, s_axis_tready);
      end
      rstn = 1'b1;
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (s_axis_tready !== 1'b1 || occupancy !== 5'd0) begin
         n_errors++;
         $display("FAIL reset_release: trdy=%b occ=%0d, required 1/0", s_axis_tready, occupancy);
      end
   endtask

   task automatic test_basic_order;
      got_q.delete();
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, 8'h11 + 8'(i), 1'b1, 1'b1);
         n_checks++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h11 + 8'(i)) begin
            n_errors++;
            $display("FAIL basic_latency[%0d]: tvalid=%b data=%h, required 1/%h",
                     i, m_axis_tvalid, m_axis_tdata, 8'h11 + 8'(i));
         end
      end
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (occupancy !== 5'd0 || got_q.size() != 5) begin
         n_errors++;
         $display("FAIL basic_drain: occ=%0d reads=%0d, required 0/5", occupancy, got_q.size());
      end
      for (int i = 0; i < got_q.size(); i++) begin
         n_checks++;
         if (got_q[i] !== 8'h11 + 8'(i)) begin
            n_errors++;
            $display("FAIL basic_order[%0d]: got %h, required %h", i, got_q[i], 8'h11 + 8'(i));
         end
      end
   endtask

   task automatic test_zero_keep;
      got_q.delete();
      tick(1'b1, 8'h01, 1'b1, 1'b0);
      tick(1'b1, 8'h55, 1'b0, 1'b0);
      tick(1'b1, 8'h02, 1'b1, 1'b0);
      n_checks++;
      if (occupancy !== 5'd2) begin
         n_errors++;
         $display("FAIL zero_keep_occ: occ=%0d, required 2", occupancy);
      end
      for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (got_q.size() != 2 || got_q[0] !== 8'h01 || got_q[1] !== 8'h02) begin
         n_errors++;
         $display("FAIL zero_keep_stream: %0d reads, required 2 reads 01,02", got_q.size());
      end
   endtask

   task automatic test_throttle;
      for (int i = 0; i < DEPTH; i++) begin
         tick(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
         n_checks++;
         if (s_axis_tready !== m_trdy || occupancy !== 5'(exp_q.size())) begin
            n_errors++;
            $display("FAIL throttle[%0d]: trdy=%b occ=%0d, required %b/%0d",
                     i, s_axis_tready, occupancy, m_trdy, exp_q.size());
         end
      end
      n_checks++;
      if (occupancy !== 5'd16 || overflow !== 1'b0 || s_axis_tready !== 1'b0) begin
         n_errors++;
         $display("FAIL throttle_full: occ=%0d ovf=%b trdy=%b, required 16/0/0",
                  occupancy, overflow, s_axis_tready);
      end
   endtask

   task automatic test_overflow;
      logic [7:0] head;
      head = exp_q[0][7:0];
      tick(1'b1, 8'hAA, 1'b1, 1'b0);
      n_checks++;
      if (overflow !== 1'b1 || occupancy !== 5'd16 || m_axis_tdata !== head) begin
         n_errors++;
         $display("FAIL overflow: ovf=%b occ=%0d head=%h, required 1/16/%h",
                  overflow, occupancy, m_axis_tdata, head);
      end
   endtask

   task automatic test_full_read;
      tick(1'b1, 8'h3C, 1'b1, 1'b1);
      n_checks++;
      if (occupancy !== 5'd16 || m_axis_tdata !== exp_q[0][7:0]) begin
         n_errors++;
         $display("FAIL full_read: occ=%0d head=%h, required 16/%h", occupancy, m_axis_tdata, exp_q[0][7:0]);
      end
      while (exp_q.size() != 0) begin
         n_checks++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[0][7:0]) begin
            n_errors++;
            $display("FAIL full_drain: tvalid=%b data=%h, required 1/%h", m_axis_tvalid, m_axis_tdata, exp_q[0][7:0]);
         end
         tick(1'b0, 8'h00, 1'b0, 1'b1);
      end
      n_checks++;
      if (overflow !== 1'b1 || occupancy !== 5'd0) begin
         n_errors++;
         $display("FAIL sticky_overflow: ovf=%b occ=%0d, required 1/0", overflow, occupancy);
      end
   endtask

   task automatic test_reset_mid;
      for (int i = 0; i < 7; i++) tick(1'b1, 8'(i), 1'b1, 1'b0);
      rstn = 1'b0;
      tick(1'b1, 8'hEE, 1'b1, 1'b0);
      n_checks++;
      if (m_axis_tvalid !== 1'b0 || occupancy !== 5'd0 || overflow !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_mid: tvalid=%b occ=%0d ovf=%b, required 0/0/0", m_axis_tvalid, occupancy, overflow);
      end
      rstn = 1'b1;
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (s_axis_tready !== 1'b1 || occupancy !== 5'd0) begin
         n_errors++;
         $display("FAIL reset_mid_release: trdy=%b occ=%0d, required 1/0", s_axis_tready, occupancy);
      end
   endtask

   task automatic test_random;
      logic v, k, mr;
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 9) < 7);
         k  = ($urandom_range(0, 6) != 0);
         mr = ($urandom_range(0, 9) < (i < 200 ? 3 : 7));
         tick(v, 8'($urandom_range(0, 255)), k, mr);
         n_checks++;
         if (m_axis_tvalid !== (exp_q.size() != 0) || occupancy !== 5'(exp_q.size()) ||
             s_axis_tready !== m_trdy || overflow !== m_ovf ||
             (exp_q.size() != 0 && m_axis_tdata !== exp_q[0][7:0])) begin
            n_errors++;
            $display("FAIL random[%0d]: tvalid=%b occ=%0d trdy=%b ovf=%b data=%h, required occ=%0d trdy=%b ovf=%b",
                     i, m_axis_tvalid, occupancy, s_axis_tready, overflow, m_axis_tdata,
                     exp_q.size(), m_trdy, m_ovf);
         end
      end
   endtask

   task automatic test_tlast;
      tick(1'b1, 8'h7E, 1'b1, 1'b0);
      for (int i = 1; i < IDLE_T; i++) begin
         tick(1'b0, 8'h00, 1'b0, 1'b0);
         n_checks++;
         if (m_axis_tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL tlast_hold[%0d]: tvalid=%b, required 0", i, m_axis_tvalid);
         end
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tdata !== 8'h7E) begin
         n_errors++;
         $display("FAIL tlast_release: tvalid=%b tlast=%b data=%h, required 1/1/7e",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      tick(1'b1, 8'hA1, 1'b1, 1'b0);
      tick(1'b1, 8'hA2, 1'b1, 1'b0);
      n_checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 8'hA1) begin
         n_errors++;
         $display("FAIL tlast_write_release: tvalid=%b tlast=%b data=%h, required 1/0/a1",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata);
      end
   endtask

   initial begin
      rstn          = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tkeep  = 1'b0;
      m_axis_tready = 1'b0;
      m_ovf         = 1'b0;
      m_trdy        = 1'b0;
      @(negedge ft245_dclk);
      test_reset();
`ifdef FT245_RX_TLAST_EN
      test_tlast();
`else
      test_basic_order();
      test_zero_keep();
      test_throttle();
      test_overflow();
      test_full_read();
      test_reset_mid();
      test_random();
      n_checks++;
      if (m_axis_tlast !== 1'b0) begin
         n_errors++;
         $display("FAIL tlast_tied: tlast=%b, required 0", m_axis_tlast);
      end
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
